// File: rtl/lights_pkg.sv
// Shared colour table, FSM encoding and RGB decode helper for the
// lights selector/decoder pair.
package lights_pkg;

    localparam logic [23:0] RGB_BLACK   = 24'h000000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;

    localparam logic [2:0] CODE_WHITE = 3'd7;

    typedef enum logic [1:0] {
        UNLOCKED,
        SETTLING,
        LOCKED
    } state_t;

    // Returns {legal, code}; illegal words map to 4'b0000.
    function automatic logic [3:0] rgb_to_code(input logic [23:0] rgb);
        logic [3:0] r;
        case (rgb)
            RGB_BLACK:   r = 4'b1000;
            RGB_BLUE:    r = 4'b1001;
            RGB_GREEN:   r = 4'b1010;
            RGB_CYAN:    r = 4'b1011;
            RGB_RED:     r = 4'b1100;
            RGB_MAGENTA: r = 4'b1101;
            RGB_YELLOW:  r = 4'b1110;
            RGB_WHITE:   r = 4'b1111;
            default:     r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lights_seq_check.sv
// Decides whether a colour change follows the selector's 1..6 cycle,
// with white acting as a wildcard on either side.
module lights_seq_check
    import lights_pkg::*;
(
    input  logic [2:0] prev_code,
    input  logic [2:0] new_code,
    input  logic       valid,
    output logic       in_order
);

    logic [2:0] succ;
    logic       in_cycle;

    always_comb begin
        succ     = (prev_code == 3'd6) ? 3'd1 : prev_code + 3'd1;
        in_cycle = (prev_code != 3'd0) && (prev_code != CODE_WHITE);
        in_order = !valid
                || (prev_code == CODE_WHITE)
                || (new_code == CODE_WHITE)
                || (in_cycle && (new_code == succ));
    end

endmodule

// File: rtl/lights_decoder.sv
// Debouncing RGB->code monitor for the lights bus: accepts stable
// words, flags illegal ones and checks colour ordering.
module lights_decoder
    import lights_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      light,
    output logic [2:0]       colour,
    output logic             white,
    output logic             valid,
    output logic             unknown,
    output logic             seq_err,
    output logic [CNT_W-1:0] changes
);

    localparam int          SW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB = SW'(STABLE_CYCLES);

    state_t        state;
    logic [23:0]   sample;
    logic [23:0]   cand;
    logic [23:0]   acc;
    logic [SW-1:0] stab_cnt;

    logic [3:0]    lut;
    logic [SW-1:0] n_cnt;
    logic          active;
    logic          accept;
    logic          in_order;

    // The sample itself is the candidate whenever acceptance fires,
    // so the decode can come straight from the sample register.
    always_comb begin
        lut    = rgb_to_code(sample);
        n_cnt  = SW'(1);
        active = 1'b0;
        case (state)
            UNLOCKED: active = 1'b1;
            SETTLING: begin
                active = 1'b1;
                if (sample == cand)
                    n_cnt = stab_cnt + SW'(1);
            end
            LOCKED:   active = (sample != acc);
            default:  active = 1'b0;
        endcase
        accept = active && (n_cnt >= STAB);
    end

    lights_seq_check u_seq (
        .prev_code (colour),
        .new_code  (lut[2:0]),
        .valid     (valid),
        .in_order  (in_order)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            sample   <= '0;
            cand     <= '0;
            acc      <= '0;
            stab_cnt <= '0;
            colour   <= '0;
            white    <= 1'b0;
            valid    <= 1'b0;
            unknown  <= 1'b0;
            seq_err  <= 1'b0;
            changes  <= '0;
        end else begin
            sample  <= light;
            unknown <= 1'b0;
            if (accept) begin
                cand     <= sample;
                stab_cnt <= '0;
                if (!lut[3]) begin
                    unknown <= 1'b1;
                    state   <= valid ? LOCKED : UNLOCKED;
                end else begin
                    acc   <= sample;
                    state <= LOCKED;
                    if (!valid) begin
                        colour <= lut[2:0];
                        white  <= (lut[2:0] == CODE_WHITE);
                        valid  <= 1'b1;
                    end else if (lut[2:0] != colour) begin
                        colour  <= lut[2:0];
                        white   <= (lut[2:0] == CODE_WHITE);
                        changes <= changes + CNT_W'(1);
                        if (!in_order)
                            seq_err <= 1'b1;
                    end
                end
            end else if (active) begin
                state    <= SETTLING;
                cand     <= sample;
                stab_cnt <= n_cnt;
            end
        end
    end

endmodule

// File: tb/tb_lights_decoder.sv
// Directed bench for lights_decoder: latency, ordering, glitches,
// illegal words and reset during settling.
module tb_lights_decoder;

    logic        clk;
    logic        rst;
    logic [23:0] light;
    logic [2:0]  colour;
    logic        white;
    logic        valid;
    logic        unknown;
    logic        seq_err;
    logic [7:0]  changes;

    int n_assert;
    int n_fail;
    int pulses;

    lights_decoder #(
        .STABLE_CYCLES (2),
        .CNT_W         (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .light   (light),
        .colour  (colour),
        .white   (white),
        .valid   (valid),
        .unknown (unknown),
        .seq_err (seq_err),
        .changes (changes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then park on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] c,
                           input logic w, input logic v,
                           input logic s, input logic [7:0] ch);
        chk({tag, ".colour"},  32'(colour),  32'(c));
        chk({tag, ".white"},   32'(white),   32'(w));
        chk({tag, ".valid"},   32'(valid),   32'(v));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(s));
        chk({tag, ".changes"}, 32'(changes), 32'(ch));
    endtask

    initial begin
        logic [23:0] steps [6];
        logic [2:0]  codes [6];
        steps = '{24'h00FF00, 24'h00FFFF, 24'hFF0000,
                  24'hFF00FF, 24'hFFFF00, 24'h0000FF};
        codes = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
        n_assert = 0;
        n_fail   = 0;

        rst   = 1'b1;
        light = 24'h000000;
        tick(2);
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset.unknown", 32'(unknown), 32'd0);

        rst   = 1'b0;
        light = 24'h0000FF;
        tick(2);
        chk("lat.edge2.valid", 32'(valid), 32'd0);
        tick(1);
        chk_all("lat.edge3", 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);

        for (int i = 0; i < 6; i++) begin
            light = steps[i];
            tick(4);
            chk($sformatf("cycle%0d.colour", i), 32'(colour), 32'(codes[i]));
        end
        chk("cycle.changes", 32'(changes), 32'd6);
        chk("cycle.seq_err", 32'(seq_err), 32'd0);

        light = 24'h00FF00;
        tick(4);
        chk_all("to2", 3'd2, 1'b0, 1'b1, 1'b0, 8'd7);
        light = 24'hFF0000;
        tick(1);
        light = 24'h00FF00;
        tick(4);
        chk_all("glitch", 3'd2, 1'b0, 1'b1, 1'b0, 8'd7);

        light = 24'hFFFFFF;
        tick(4);
        chk_all("white", 3'd7, 1'b1, 1'b1, 1'b0, 8'd8);
        light = 24'h00FFFF;
        tick(4);
        chk_all("from_white", 3'd3, 1'b0, 1'b1, 1'b0, 8'd9);
        light = 24'h0000FF;
        tick(4);
        chk_all("out_of_order", 3'd1, 1'b0, 1'b1, 1'b1, 8'd10);
        light = 24'h00FF00;
        tick(4);
        chk_all("sticky", 3'd2, 1'b0, 1'b1, 1'b1, 8'd11);

        pulses = 0;
        light  = 24'h123456;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (unknown) pulses++;
            if (i == 2) light = 24'h00FF00;
        end
        chk("illegal.pulses", 32'(pulses), 32'd1);
        chk_all("illegal", 3'd2, 1'b0, 1'b1, 1'b1, 8'd11);

        light = 24'hFF0000;
        tick(4);
        chk_all("to4", 3'd4, 1'b0, 1'b1, 1'b1, 8'd12);
        light = 24'h00FF00;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk_all("rst_settle", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst_settle.unknown", 32'(unknown), 32'd0);

        rst   = 1'b0;
        light = 24'hFF0000;
        tick(4);
        chk_all("post_rst", 3'd4, 1'b0, 1'b1, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
